// File: rtl/hc_ctrl_pkg.sv
// Shared types for the push-button control slice: the repeat FSM state
// and the width helper for the channel-select index.
package hc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } rpt_state_t;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// One push-button channel: 2-FF synchronizer, debouncer and the
// IDLE/HOLD/REPEAT/LOCK auto-repeat FSM that produces step ticks.
module btn_repeat
    import hc_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       btn,
    input  logic       lock,
    input  logic       inhibit,
    output logic       level,
    output logic       press,
    output logic       tick,
    output logic [1:0] dbg_state
);

    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    logic [1:0]    sync;
    logic          level_d;
    logic [DW-1:0] db_cnt;

    rpt_state_t    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          tick_nx;

    // The debounced level only moves after the synchronized input has
    // disagreed with it for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sync    <= 2'b11;
            level   <= 1'b1;
            level_d <= 1'b1;
            db_cnt  <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            if (sync[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                level  <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = level_d & ~level;

    always_comb begin
        state_nx = state;
        timer_nx = timer + 1'b1;
        tick_nx  = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (press) begin
                    state_nx = HOLD;
                    tick_nx  = 1'b1;
                end
            end
            HOLD: begin
                if (level) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (lock) begin
                    state_nx = LOCK;
                    timer_nx = '0;
                end else if (timer == TW'(HOLD_CYC - 1)) begin
                    state_nx = REPEAT;
                    tick_nx  = 1'b1;
                    timer_nx = '0;
                end
            end
            REPEAT: begin
                if (level) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (lock) begin
                    state_nx = LOCK;
                    timer_nx = '0;
                end else if (timer == TW'(REPEAT_CYC - 1)) begin
                    tick_nx  = 1'b1;
                    timer_nx = '0;
                end
            end
            LOCK: begin
                timer_nx = '0;
                if (level) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // Ticks are masked, not the FSM, so a two-button hold still times out normally.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
            timer <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            tick  <= tick_nx & ~inhibit;
        end
    end

    assign dbg_state = state;

endmodule

// File: rtl/num2seg.sv
// Two-digit hex 7-segment encoder: each byte is {dp, g, f, e, d, c, b, a},
// active-high; the low byte shows the low nibble.
module num2seg #(
    parameter int DP = 3
) (
    input  logic [7:0]  num,
    output logic [15:0] seg
);

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // DP selects which digit lights its point; values outside 0..1 light none.
    localparam logic DP0 = (DP == 0);
    localparam logic DP1 = (DP == 1);

    assign seg = {DP1, hex7(num[7:4]), DP0, hex7(num[3:0])};

endmodule

// File: rtl/multi_value_control.sv
// N_CH saturating setpoints edited by shared inc/dec buttons with
// auto-repeat; a select button picks the channel shown on the display.
module multi_value_control
    import hc_ctrl_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int N_BIT        = 8,
    parameter int INTEGER_STEP = 1,
    parameter int INTEGER_MIN  = 0,
    parameter int INTEGER_MAX  = 255,
    parameter int INTEGER_RST  = 0,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter int DP           = 3,
    parameter int SHIFT        = 0
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic                       inc_btn,
    input  logic                       dec_btn,
    input  logic                       sel_btn,
    output logic [N_CH*N_BIT-1:0]      count,
    output logic [sel_width(N_CH)-1:0] o_sel,
    output logic                       o_update,
    output logic [15:0]                o_seg,
    output logic [7:0]                 o_seg0,
    output logic [7:0]                 o_seg1
);

    localparam int SEL_W = sel_width(N_CH);
    localparam logic [N_BIT:0]   STEP_W = (N_BIT + 1)'(INTEGER_STEP);
    localparam logic [N_BIT:0]   MIN_W  = (N_BIT + 1)'(INTEGER_MIN);
    localparam logic [N_BIT:0]   MAX_W  = (N_BIT + 1)'(INTEGER_MAX);
    localparam logic [N_BIT-1:0] RST_V  = N_BIT'(INTEGER_RST);

    logic       inc_level, inc_press, inc_tick;
    logic       dec_level, dec_press, dec_tick;
    logic       sel_level, sel_press, sel_tick;
    logic [1:0] inc_state, dec_state, sel_state;
    logic       both_held;

    assign both_held = ~inc_level & ~dec_level;

    btn_repeat #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
    ) u_inc (
        .i_CLK(i_CLK), .i_RST(i_RST), .btn(inc_btn), .lock(sel_press),
        .inhibit(both_held), .level(inc_level), .press(inc_press),
        .tick(inc_tick), .dbg_state(inc_state)
    );

    btn_repeat #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
    ) u_dec (
        .i_CLK(i_CLK), .i_RST(i_RST), .btn(dec_btn), .lock(sel_press),
        .inhibit(both_held), .level(dec_level), .press(dec_press),
        .tick(dec_tick), .dbg_state(dec_state)
    );

    // Only the debounced press edge of the select button is used.
    btn_repeat #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
    ) u_sel (
        .i_CLK(i_CLK), .i_RST(i_RST), .btn(sel_btn), .lock(1'b0),
        .inhibit(1'b0), .level(sel_level), .press(sel_press),
        .tick(sel_tick), .dbg_state(sel_state)
    );

    logic unused_dbg;
    assign unused_dbg = ^{inc_press, dec_press, sel_level, sel_tick,
                          inc_state, dec_state, sel_state};

    logic [N_BIT-1:0] val [N_CH];
    logic [N_BIT-1:0] cur, nxt;
    logic [N_BIT:0]   wide;

    // Arithmetic is one bit wider than the value so neither bound can wrap.
    always_comb begin
        cur  = val[o_sel];
        nxt  = cur;
        wide = '0;
        if (inc_tick && !dec_tick) begin
            wide = {1'b0, cur} + STEP_W;
            nxt  = (wide > MAX_W) ? MAX_W[N_BIT-1:0] : wide[N_BIT-1:0];
        end else if (dec_tick && !inc_tick) begin
            wide = {1'b0, cur};
            nxt  = (wide < MIN_W + STEP_W) ? MIN_W[N_BIT-1:0]
                                          : cur - STEP_W[N_BIT-1:0];
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int k = 0; k < N_CH; k++) val[k] <= RST_V;
            o_sel    <= '0;
            o_update <= 1'b0;
        end else begin
            o_update <= 1'b0;
            if (nxt != cur) begin
                val[o_sel] <= nxt;
                o_update   <= 1'b1;
            end
            if (sel_press) begin
                o_sel <= (o_sel == SEL_W'(N_CH - 1)) ? '0 : o_sel + 1'b1;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < N_CH; k++) count[k*N_BIT +: N_BIT] = val[k];
    end

    logic [7:0] disp;
    assign disp = 8'(cur >> SHIFT);

    num2seg #(.DP(DP)) u_seg (
        .num(disp),
        .seg(o_seg)
    );

    assign o_seg0 = o_seg[7:0];
    assign o_seg1 = o_seg[15:8];

endmodule

// File: tb/tb_multi_value_control.sv
// Directed bench for multi_value_control with two channels, STEP=5,
// bounds 3..20, reset value 10 and short debounce/hold/repeat times.
module tb_multi_value_control;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        inc_btn, dec_btn, sel_btn;
    logic [15:0] count;
    logic [0:0]  o_sel;
    logic        o_update;
    logic [15:0] o_seg;
    logic [7:0]  o_seg0, o_seg1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          upd_cyc[$];
    logic [15:0] upd_val[$];
    logic [15:0] exp_q[$];

    multi_value_control #(
        .N_CH(2), .N_BIT(8), .INTEGER_STEP(5), .INTEGER_MIN(3),
        .INTEGER_MAX(20), .INTEGER_RST(10), .DEBOUNCE_CYC(4),
        .HOLD_CYC(20), .REPEAT_CYC(8), .DP(3), .SHIFT(0)
    ) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .sel_btn(sel_btn), .count(count), .o_sel(o_sel), .o_update(o_update),
        .o_seg(o_seg), .o_seg0(o_seg0), .o_seg1(o_seg1)
    );

    // clock / cycle counter / update monitor
    always #5 i_CLK = ~i_CLK;
    always @(posedge i_CLK) cyc <= cyc + 1;
    always @(negedge i_CLK) begin
        if (o_update === 1'b1) begin
            upd_cyc.push_back(cyc);
            upd_val.push_back(count);
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge i_CLK);
        #1;
    endtask

    task automatic clear_log();
        upd_cyc.delete();
        upd_val.delete();
    endtask

    task automatic do_reset();
        step(1);
        i_RST = 1'b1;
        inc_btn = 1'b1; dec_btn = 1'b1; sel_btn = 1'b1;
        step(3);
        i_RST = 1'b0;
        step(3);
        clear_log();
    endtask

    task automatic press_inc(input int hold, input int idle);
        inc_btn = 1'b0; step(hold); inc_btn = 1'b1; step(idle);
    endtask

    task automatic press_dec(input int hold, input int idle);
        dec_btn = 1'b0; step(hold); dec_btn = 1'b1; step(idle);
    endtask

    task automatic press_sel(input int hold, input int idle);
        sel_btn = 1'b0; step(hold); sel_btn = 1'b1; step(idle);
    endtask

    // tests
    task automatic test_reset();
        i_RST = 1'b1;
        inc_btn = 1'b1; dec_btn = 1'b1; sel_btn = 1'b1;
        step(3);
        checks++; if (count !== 16'h0A0A) begin errors++; $display("FAIL reset_count got=%h exp=%h", count, 16'h0A0A); end
        checks++; if (o_sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%h exp=0", o_sel); end
        checks++; if (o_update !== 1'b0) begin errors++; $display("FAIL reset_update got=%b exp=0", o_update); end
        checks++; if (o_seg !== 16'h3F77) begin errors++; $display("FAIL reset_seg got=%h exp=%h", o_seg, 16'h3F77); end
        checks++; if (o_seg0 !== 8'h77) begin errors++; $display("FAIL reset_seg0 got=%h exp=77", o_seg0); end
        checks++; if (o_seg1 !== 8'h3F) begin errors++; $display("FAIL reset_seg1 got=%h exp=3f", o_seg1); end
        i_RST = 1'b0;
        step(3);
        clear_log();
    endtask

    task automatic test_single_inc();
        int t0;
        do_reset();
        t0 = cyc;
        press_inc(10, 20);
        checks++; if (upd_cyc.size() != 1) begin errors++; $display("FAIL single_upd_count got=%0d exp=1", upd_cyc.size()); end
        checks++; if (upd_cyc.size() > 0 && upd_cyc[0] - t0 != 8) begin errors++; $display("FAIL single_latency got=%0d exp=8", upd_cyc[0] - t0); end
        checks++; if (count[7:0] !== 8'd15) begin errors++; $display("FAIL single_ch0 got=%0d exp=15", count[7:0]); end
        checks++; if (count[15:8] !== 8'd10) begin errors++; $display("FAIL single_ch1 got=%0d exp=10", count[15:8]); end
        checks++; if (o_seg !== 16'h3F71) begin errors++; $display("FAIL single_seg got=%h exp=3f71", o_seg); end
    endtask

    task automatic test_hold_saturate();
        do_reset();
        press_inc(60, 20);
        checks++; if (upd_cyc.size() != 2) begin errors++; $display("FAIL hold_upd_count got=%0d exp=2", upd_cyc.size()); end
        if (upd_cyc.size() == 2) begin
            checks++; if (upd_val[0][7:0] !== 8'd15) begin errors++; $display("FAIL hold_first got=%0d exp=15", upd_val[0][7:0]); end
            checks++; if (upd_val[1][7:0] !== 8'd20) begin errors++; $display("FAIL hold_second got=%0d exp=20", upd_val[1][7:0]); end
            checks++; if (upd_cyc[1] - upd_cyc[0] != 20) begin errors++; $display("FAIL hold_gap got=%0d exp=20", upd_cyc[1] - upd_cyc[0]); end
        end
        checks++; if (count !== 16'h0A14) begin errors++; $display("FAIL hold_final got=%h exp=0a14", count); end
    endtask

    task automatic test_repeat_rate();
        int gaps[3] = '{20, 8, 8};
        do_reset();
        press_dec(10, 20);
        press_dec(10, 20);
        clear_log();
        exp_q = '{16'h0A08, 16'h0A0D, 16'h0A12, 16'h0A14};
        press_inc(50, 20);
        checks++; if (upd_val.size() != exp_q.size()) begin errors++; $display("FAIL repeat_upd_count got=%0d exp=%0d", upd_val.size(), exp_q.size()); end
        if (upd_val.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (upd_val[i] !== exp_q[i]) begin errors++; $display("FAIL repeat_val[%0d] got=%h exp=%h", i, upd_val[i], exp_q[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                checks++; if (upd_cyc[i+1] - upd_cyc[i] != gaps[i]) begin errors++; $display("FAIL repeat_gap[%0d] got=%0d exp=%0d", i, upd_cyc[i+1] - upd_cyc[i], gaps[i]); end
            end
        end
    endtask

    task automatic test_dec_clamp();
        do_reset();
        press_dec(10, 20);
        checks++; if (count[7:0] !== 8'd5) begin errors++; $display("FAIL dec_first got=%0d exp=5", count[7:0]); end
        press_dec(10, 20);
        checks++; if (count[7:0] !== 8'd3) begin errors++; $display("FAIL dec_clamp got=%0d exp=3", count[7:0]); end
        press_dec(10, 20);
        checks++; if (count[7:0] !== 8'd3) begin errors++; $display("FAIL dec_floor got=%0d exp=3", count[7:0]); end
        checks++; if (upd_cyc.size() != 2) begin errors++; $display("FAIL dec_upd_count got=%0d exp=2", upd_cyc.size()); end
    endtask

    task automatic test_glitch();
        do_reset();
        press_inc(2, 20);
        press_inc(3, 20);
        checks++; if (count !== 16'h0A0A) begin errors++; $display("FAIL glitch_count got=%h exp=0a0a", count); end
        checks++; if (upd_cyc.size() != 0) begin errors++; $display("FAIL glitch_upd got=%0d exp=0", upd_cyc.size()); end
        press_inc(4, 20);
        checks++; if (count[7:0] !== 8'd15) begin errors++; $display("FAIL min_press got=%0d exp=15", count[7:0]); end
    endtask

    task automatic test_both_held();
        do_reset();
        inc_btn = 1'b0; dec_btn = 1'b0;
        step(30);
        inc_btn = 1'b1; dec_btn = 1'b1;
        step(20);
        checks++; if (count !== 16'h0A0A) begin errors++; $display("FAIL both_count got=%h exp=0a0a", count); end
        checks++; if (upd_cyc.size() != 0) begin errors++; $display("FAIL both_upd got=%0d exp=0", upd_cyc.size()); end
    endtask

    task automatic test_sel_lock();
        do_reset();
        inc_btn = 1'b0;
        step(40);
        sel_btn = 1'b0;
        step(6);
        checks++; if (o_sel !== 1'b0) begin errors++; $display("FAIL sel_early got=%h exp=0", o_sel); end
        step(1);
        checks++; if (o_sel !== 1'b1) begin errors++; $display("FAIL sel_edge got=%h exp=1", o_sel); end
        step(3);
        sel_btn = 1'b1;
        step(30);
        checks++; if (count !== 16'h0A14) begin errors++; $display("FAIL sel_lock_count got=%h exp=0a14", count); end
        checks++; if (upd_cyc.size() != 2) begin errors++; $display("FAIL sel_lock_upd got=%0d exp=2", upd_cyc.size()); end
        inc_btn = 1'b1;
        step(20);
        press_inc(10, 20);
        checks++; if (count !== 16'h0F14) begin errors++; $display("FAIL sel_ch1 got=%h exp=0f14", count); end
        checks++; if (o_seg !== 16'h3F71) begin errors++; $display("FAIL sel_seg got=%h exp=3f71", o_seg); end
        checks++; if (o_seg0 !== 8'h71 || o_seg1 !== 8'h3F) begin errors++; $display("FAIL sel_seg_bytes got=%h/%h exp=3f/71", o_seg1, o_seg0); end
        press_sel(10, 20);
        checks++; if (o_sel !== 1'b0) begin errors++; $display("FAIL sel_wrap got=%h exp=0", o_sel); end
        checks++; if (o_seg !== 16'h0666) begin errors++; $display("FAIL sel_wrap_seg got=%h exp=0666", o_seg); end
    endtask

    task automatic test_reset_mid_repeat();
        int t0;
        do_reset();
        press_sel(10, 20);
        inc_btn = 1'b0;
        step(35);
        checks++; if (count !== 16'h140A) begin errors++; $display("FAIL mid_pre got=%h exp=140a", count); end
        i_RST = 1'b1;
        #1;
        checks++; if (count !== 16'h0A0A) begin errors++; $display("FAIL mid_rst_count got=%h exp=0a0a", count); end
        checks++; if (o_sel !== 1'b0) begin errors++; $display("FAIL mid_rst_sel got=%h exp=0", o_sel); end
        checks++; if (o_update !== 1'b0) begin errors++; $display("FAIL mid_rst_update got=%b exp=0", o_update); end
        step(3);
        i_RST = 1'b0;
        t0 = cyc;
        clear_log();
        step(5);
        checks++; if (upd_cyc.size() != 0) begin errors++; $display("FAIL mid_no_early_tick got=%0d exp=0", upd_cyc.size()); end
        step(10);
        inc_btn = 1'b1;
        step(20);
        checks++; if (upd_cyc.size() != 1) begin errors++; $display("FAIL mid_upd_count got=%0d exp=1", upd_cyc.size()); end
        checks++; if (upd_cyc.size() > 0 && upd_cyc[0] - t0 != 8) begin errors++; $display("FAIL mid_refall_latency got=%0d exp=8", upd_cyc[0] - t0); end
        checks++; if (count !== 16'h0A0F) begin errors++; $display("FAIL mid_final got=%h exp=0a0f", count); end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_hold_saturate();
        test_repeat_rate();
        test_dec_clamp();
        test_glitch();
        test_both_held();
        test_sel_lock();
        test_reset_mid_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_value_control.md
# multi_value_control

Multi-channel successor to the single-value button counter: holds `N_CH` independent saturating values, each adjusted through shared debounced increment and decrement buttons. Holding a button past a threshold auto-repeats the step. A third button selects which channel is edited. Sits between the board push-buttons and the converter control parameters, such as phase, dead-time and frequency setpoints. Drives the 7-segment display with the selected channel's value.

## Interface
Parameters:
- `N_CH`, 4: number of channels, ≥1
- `N_BIT`, 8: width of each value
- `INTEGER_STEP`, 1: step per press or per repeat tick
- `INTEGER_MIN`, 0: lower saturation bound, unsigned
- `INTEGER_MAX`, 255: upper saturation bound, ≤ 2^N_BIT−1
- `INTEGER_RST`, 0: reset value of every channel
- `DEBOUNCE_CYC`, 50000: stable cycles required to accept a level change
- `HOLD_CYC`, 25000000: cycles a press must be held before auto-repeat starts
- `REPEAT_CYC`, 5000000: cycles between repeat steps
- `DP`, 3 and `SHIFT`, 0: display decimal point and right-shift, passed to `num2seg`

Ports:
- `i_CLK` in 1: system clock
- `i_RST` in 1: asynchronous, active-high reset
- `inc_btn` in 1: increment button, active-low, asynchronous to `i_CLK`
- `dec_btn` in 1: decrement button, active-low, asynchronous
- `sel_btn` in 1: channel-select button, active-low, asynchronous
- `count` out N_CH*N_BIT: channel k is at bits [k*N_BIT +: N_BIT]
- `o_sel` out max(1,$clog2(N_CH)): index of the selected channel
- `o_update` out 1: one-cycle pulse when any channel value changes
- `o_seg` out 16: `num2seg` output of (selected value >> SHIFT)
- `o_seg0` and `o_seg1` out 8: low and high bytes of `o_seg`

## Operation
- Each button goes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYC` consecutive cycles.
- Press event: debounced level falls 1→0. Reset value of the debounced level is 1 (released).
- Each of the inc and dec buttons has its own repeat FSM with states IDLE, HOLD, REPEAT and LOCK.
  - IDLE, on press: emit one step tick, go to HOLD, clear the timer.
  - HOLD: after `HOLD_CYC` cycles still pressed, emit a tick and go to REPEAT. On release, go to IDLE.
  - REPEAT: emit a tick every `REPEAT_CYC` cycles. On release, go to IDLE.
  - LOCK: emit no ticks. Exit to IDLE on release.
- Simultaneous ticks: if inc and dec tick in the same cycle, both are dropped and the value is unchanged.
- Held together: while both debounced levels are 0, neither FSM emits ticks.
- Saturating arithmetic, computed in N_BIT+1 bits so nothing wraps:
  - inc: new = min(v+STEP, MAX)
  - dec: new = max(v−STEP, MIN), where v<MIN+STEP clamps to MIN
- A tick at a bound leaves the value unchanged and gives no `o_update`.
- Only the channel at `o_sel` is modified.
- sel press advances `o_sel` by one, wrapping N_CH−1 → 0. With N_CH=1, `o_sel` stays 0.
- A sel press forces both repeat FSMs that are in HOLD or REPEAT into LOCK. A held inc or dec button therefore never edits the newly selected channel.
- Reset (asynchronous, any time including mid-hold) gives:
  - all channels = `INTEGER_RST`
  - `o_sel` = 0
  - `o_update` = 0
  - FSMs in IDLE, timers 0, debounced levels 1, synchronizer flops 1
- `o_seg` follows the post-reset value combinationally.

## Timing
- Raw button edge to debounced edge: 2 + `DEBOUNCE_CYC` cycles, ±1 cycle for the input sampling phase.
- Debounced press to tick: tick is registered in the same clock edge that updates the FSM.
- Tick to `count` update: 1 cycle. `o_update` is high in the same cycle the new `count` is first visible.
- First press to first repeat step: `HOLD_CYC` cycles after the initial tick. Subsequent repeat steps are exactly `REPEAT_CYC` cycles apart.
- `o_sel` updates 1 cycle after the debounced sel press.
- `o_seg` is combinational from the registered value and `o_sel`.

## Structure
- Shared package `hc_ctrl_pkg`: repeat FSM state enum (IDLE, HOLD, REPEAT, LOCK) and the helper function for the `o_sel` width.
- Sub-module `btn_repeat`, instantiated twice (inc and dec), contains:
  - synchronizer, debouncer and repeat FSM
  - outputs: debounced level, tick, lock input
- `sel_btn` reuses `btn_repeat` with the repeat FSM unused; only its press tick is taken.
- The existing `num2seg` drives the display.

## Test plan
Test parameters: N_CH=2, N_BIT=8, STEP=5, MIN=3, MAX=20, RST=10, DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8.

- Reset, then a single inc press of 10 cycles: ch0 goes 10→15, `o_update` pulses once, ch1 stays 10.
- Inc held for 60 cycles from 10: ch0 steps 15, then 20 at +20 cycles, then stays at 20 for later ticks (saturated, no `o_update`).
- Dec presses from 10: ch0 goes 5, then 3 (clamped), then stays 3. No wrap below 0.
- 2-cycle glitches on inc: no value change.
- Inc and dec pressed together: no change.
- Inc held into REPEAT, then sel pressed: `o_sel`=1, ch1 unchanged until inc is released and pressed again. Two sel presses return `o_sel` to 0.
- `i_RST` asserted mid-REPEAT: all channels = 10, `o_sel`=0 immediately. After release with inc still held, no tick until the debounced level reports a new fall.
